vita_rx_packetizer: RTL

- Receive-direction counterpart of the TX deframer.
- Takes a timestamped 32-bit sample stream and emits 36-bit VITA-49 data packets (flags[35:32] + data[31:0]) toward the ethernet/packet-router FIFO.
- Inserts the header, stream ID, 64-bit timestamp, fixed-length payload and trailer.
- Header fields and samples-per-packet come from the settings bus.

---
 rtl/vita_rx_packetizer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/vita_rx_packetizer.sv
// vita_rx_packetizer: wraps a timestamped 32-bit sample stream into 36-bit
// VITA-49 data packets (flags[35:32] + data[31:0]) for the packet-router FIFO.
// Optional macro VITA_RX_PKT_TRANS_HEADER_EN: when defined, a leading TRANS word
// {20'd0, seqnum} carries SOF; when undefined, the packet starts at the HDR word.
module vita_rx_packetizer #(
    parameter int BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] vita_time,
    input  logic [31:0] sample_i,
    input  logic        sample_eob_i,
    input  logic        sample_src_rdy_i,
    output logic        sample_dst_rdy_o,
    output logic [35:0] data_o,
    output logic        src_rdy_o,
    input  logic        dst_rdy_i,
    output logic [11:0] seqnum_o
);

    localparam logic [7:0] ADDR_HDR   = 8'(BASE);
    localparam logic [7:0] ADDR_SID   = 8'(BASE + 1);
    localparam logic [7:0] ADDR_TRAIL = 8'(BASE + 2);
    localparam logic [7:0] ADDR_SPP   = 8'(BASE + 3);

    typedef enum logic [3:0] {
        IDLE, TRANS, HDR, SID, SECS, TICHI, TICLO, PAYLOAD, PAD, TRAIL
    } state_t;

    state_t      state;
    logic [31:0] hdr_tpl;
    logic [31:0] stream_id;
    logic [31:0] trail_tpl;
    logic [15:0] spp_reg;
    logic [31:0] w_hdr;
    logic [31:0] w_sid;
    logic [31:0] w_trail;
    logic [15:0] w_spp;
    logic [63:0] ts_reg;
    logic [11:0] seqnum;
    logic [15:0] cnt;
    logic        eob_flag;
    logic [31:0] word_r;
    logic        sof_r;
    logic        eof_r;
    logic        vld_r;
    logic [15:0] snap_spp;
    logic [15:0] last_idx;
    logic        xfer_r;
    logic        in_payload;

    // A zero sample count would produce an empty payload, so it is promoted to one
    assign snap_spp   = (spp_reg == 16'd0) ? 16'd1 : spp_reg;
    assign last_idx   = w_spp - 16'd1;
    assign xfer_r     = vld_r && dst_rdy_i;
    assign in_payload = (state == PAYLOAD);

    // Payload samples pass straight through; every other word comes from registers
    assign src_rdy_o        = in_payload ? sample_src_rdy_i : vld_r;
    assign sample_dst_rdy_o = in_payload && dst_rdy_i;
    assign data_o           = in_payload ? {4'b0000, sample_i}
                                         : {2'b00, eof_r, sof_r, word_r};
    assign seqnum_o         = seqnum;

    function automatic logic [31:0] hdr_word(input logic [31:0] tpl,
                                             input logic [11:0] seq,
                                             input logic [15:0] spp);
        return {tpl[31:20], seq[3:0], spp + 16'd6};
    endfunction

    // Settings-bus registers; clear leaves them untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_tpl   <= '0;
            stream_id <= '0;
            trail_tpl <= '0;
            spp_reg   <= 16'd1;
        end else if (set_stb) begin
            if (set_addr == ADDR_HDR)   hdr_tpl   <= set_data;
            if (set_addr == ADDR_SID)   stream_id <= set_data;
            if (set_addr == ADDR_TRAIL) trail_tpl <= set_data;
            if (set_addr == ADDR_SPP)   spp_reg   <= set_data[15:0];
        end
    end

    // Packet FSM: snapshots settings at packet start and registers each header word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            word_r   <= '0;
            sof_r    <= 1'b0;
            eof_r    <= 1'b0;
            vld_r    <= 1'b0;
            seqnum   <= '0;
            cnt      <= '0;
            eob_flag <= 1'b0;
            ts_reg   <= '0;
            w_hdr    <= '0;
            w_sid    <= '0;
            w_trail  <= '0;
            w_spp    <= 16'd1;
        end else if (clear) begin
            state    <= IDLE;
            word_r   <= '0;
            sof_r    <= 1'b0;
            eof_r    <= 1'b0;
            vld_r    <= 1'b0;
            seqnum   <= '0;
            cnt      <= '0;
            eob_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_src_rdy_i) begin
                        ts_reg   <= vita_time;
                        w_hdr    <= hdr_tpl;
                        w_sid    <= stream_id;
                        w_trail  <= trail_tpl;
                        w_spp    <= snap_spp;
                        cnt      <= '0;
                        eob_flag <= 1'b0;
                        vld_r    <= 1'b1;
                        sof_r    <= 1'b1;
                        eof_r    <= 1'b0;
`ifdef VITA_RX_PKT_TRANS_HEADER_EN
                        state    <= TRANS;
                        word_r   <= {20'd0, seqnum};
`else
                        state    <= HDR;
                        word_r   <= hdr_word(hdr_tpl, seqnum, snap_spp);
`endif
                    end
                end
                TRANS: begin
                    if (xfer_r) begin
                        state  <= HDR;
                        sof_r  <= 1'b0;
                        word_r <= hdr_word(w_hdr, seqnum, w_spp);
                    end
                end
                HDR: begin
                    if (xfer_r) begin
                        state  <= SID;
                        sof_r  <= 1'b0;
                        word_r <= w_sid;
                    end
                end
                SID: begin
                    if (xfer_r) begin
                        state  <= SECS;
                        word_r <= ts_reg[63:32];
                    end
                end
                SECS: begin
                    if (xfer_r) begin
                        state  <= TICHI;
                        word_r <= 32'd0;
                    end
                end
                TICHI: begin
                    if (xfer_r) begin
                        state  <= TICLO;
                        word_r <= ts_reg[31:0];
                    end
                end
                TICLO: begin
                    if (xfer_r) begin
                        state  <= PAYLOAD;
                        vld_r  <= 1'b0;
                        word_r <= '0;
                    end
                end
                PAYLOAD: begin
                    if (sample_src_rdy_i && dst_rdy_i) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == last_idx) begin
                            state    <= TRAIL;
                            word_r   <= w_trail | {31'd0, sample_eob_i};
                            eof_r    <= 1'b1;
                            vld_r    <= 1'b1;
                            eob_flag <= sample_eob_i;
                        end else if (sample_eob_i) begin
                            state    <= PAD;
                            word_r   <= 32'd0;
                            vld_r    <= 1'b1;
                            eob_flag <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (xfer_r) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == last_idx) begin
                            state  <= TRAIL;
                            word_r <= w_trail | {31'd0, eob_flag};
                            eof_r  <= 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (xfer_r) begin
                        state    <= IDLE;
                        seqnum   <= seqnum + 12'd1;
                        eob_flag <= 1'b0;
                        vld_r    <= 1'b0;
                        eof_r    <= 1'b0;
                        word_r   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
